ringn_gen_sync: RTL and testbench

RINGN_GEN_SYNC -- requirements
Module: ringn_gen_sync

---
 rtl/ringn_gen_sync.sv | 131 +++++++++++++
 tb/tb_ringn_gen_sync.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ringn_gen_sync.sv
`default_nettype none
// ============================================================================
// Module      : ringn_gen_sync
// Description : Clocked model of a self-timed multirail ring oscillator.
//               Each stage holds a RAILS-bit code (all-zero = NULL,
//               one-hot = DATA). Every rail is a C-element of its input and
//               its enable, evaluated once per rising clock edge, so the
//               whole ring advances in lock-step with no combinational path
//               between stage registers. One DATA token circulates; each pass
//               through the wrap-around stage rotates it down by one rail.
//               Stage TAP is presented on `out` and is handshaked with an
//               external consumer through out_comp.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk        : clock, all state changes on the rising edge
//   init       : asynchronous active-high reset
//   run        : 1 = ring advances, 0 = ring, J and count frozen
//   out_comp   : consumer completion (1 = DATA taken, 0 = NULL taken)
//   out        : stage TAP register contents
//   data_count : DATA wavefronts emitted on out, modulo 2^CNT_W
//   err        : sticky, set when any stage holds a multi-hot code
// ============================================================================
module ringn_gen_sync #(
    parameter int RAILS  = 4,
    parameter int STAGES = 4,
    parameter int TAP    = 2,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             init,
    input  logic             run,
    input  logic             out_comp,
    output logic [RAILS-1:0] out,
    output logic [CNT_W-1:0] data_count,
    output logic             err
);

    logic [RAILS-1:0]  w_z   [STAGES];  // current stage registers
    logic [RAILS-1:0]  w_nxt [STAGES];  // C-element results for each stage
    logic [STAGES-1:0] w_comp;          // per-stage completion (OR of rails)
    logic [STAGES-1:0] w_multi;         // per-stage illegal multi-hot flag
    logic              r_j;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_err;
    logic              w_j_c;
    logic              w_tap_rise;

    genvar k;
    generate
        for (k = 0; k < STAGES; k++) begin : g_stage
            // The last stage wakes up holding rail-0 DATA; everything else NULL.
            localparam logic [RAILS-1:0] c_RST = (k == STAGES - 1) ? RAILS'(1) : '0;

            logic [RAILS-1:0] r_z;
            logic [RAILS-1:0] w_a;
            logic             w_en;
            logic [RAILS-1:0] w_en_v;

            if (k == 0) begin : g_wrap
                // Rotate right by one rail on the wrap: rail r takes rail r+1,
                // so the token steps down one rail per trip round the ring.
                assign w_a = {w_z[STAGES-1][0], w_z[STAGES-1][RAILS-1:1]};
            end else begin : g_link
                assign w_a = w_z[k-1];
            end

            if (k == TAP) begin : g_en_tap
                // The output stage is paced by the consumer handshake.
                assign w_en = ~r_j;
            end else begin : g_en_ring
                assign w_en = ~w_comp[(k + 1) % STAGES];
            end

            assign w_en_v   = {RAILS{w_en}};
            assign w_nxt[k] = (w_a & w_en_v) | (r_z & (w_a | w_en_v));

            always_ff @(posedge clk or posedge init) begin
                if (init) begin
                    r_z <= c_RST;
                end else if (run) begin
                    r_z <= w_nxt[k];
                end
            end

            assign w_z[k]     = r_z;
            assign w_comp[k]  = |r_z;
            // x & (x-1) clears the lowest set bit; anything left means >= 2 rails.
            assign w_multi[k] = |(r_z & (r_z - RAILS'(1)));
        end
    endgenerate

    // Completion of the stage after the tap combined with the consumer's
    // acknowledgement decides when the tap may take the next wavefront.
    assign w_j_c = w_comp[TAP+1];

    // Count on the same edge that loads DATA into the tap so the count and
    // the new wavefront appear together.
    assign w_tap_rise = (|w_nxt[TAP]) & ~w_comp[TAP];

    always_ff @(posedge clk or posedge init) begin
        if (init) begin
            r_j <= 1'b0;
        end else if (run) begin
            r_j <= (w_j_c & out_comp) | (r_j & (w_j_c | out_comp));
        end
    end

    always_ff @(posedge clk or posedge init) begin
        if (init) begin
            r_cnt <= '0;
        end else if (run && w_tap_rise) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Error detection keeps watching while the ring is frozen.
    always_ff @(posedge clk or posedge init) begin
        if (init) begin
            r_err <= 1'b0;
        end else if (|w_multi) begin
            r_err <= 1'b1;
        end
    end

    assign out        = w_z[TAP];
    assign data_count = r_cnt;
    assign err        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_ringn_gen_sync.sv
`default_nettype none
// ============================================================================
// Module      : tb_ringn_gen_sync
// Description : Self-checking bench for ringn_gen_sync. Two instances:
//               A = 4 rails / 4 stages / tap 2 / 16-bit count,
//               B = 3 rails / 6 stages / tap 3 / 2-bit count.
//               Expected DATA wavefronts are queued when the bench lets the
//               ring run and popped whenever out rises from NULL to DATA.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ringn_gen_sync;

    typedef struct {
        logic [3:0]  o;
        logic [15:0] c;
    } exp_t;

    typedef struct {
        int          freeze;   // cycles of run=0 applied before this wavefront
        logic [3:0]  exp_out;
        logic [15:0] exp_cnt;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        a_init, a_run, a_oc;
    logic [3:0]  a_out;
    logic [15:0] a_cnt;
    logic        a_err;

    logic        b_init, b_run, b_oc;
    logic [2:0]  b_out;
    logic [1:0]  b_cnt;
    logic        b_err;

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t qa[$];
    exp_t qb[$];
    bit   a_follow, b_follow;
    bit   a_prev, b_prev;
    vec_t tab_a [20];
    vec_t tab_b [5];
    exp_t e_tmp;

    ringn_gen_sync #(.RAILS(4), .STAGES(4), .TAP(2), .CNT_W(16)) dut_a (
        .clk        (clk),
        .init       (a_init),
        .run        (a_run),
        .out_comp   (a_oc),
        .out        (a_out),
        .data_count (a_cnt),
        .err        (a_err)
    );

    ringn_gen_sync #(.RAILS(3), .STAGES(6), .TAP(3), .CNT_W(2)) dut_b (
        .clk        (clk),
        .init       (b_init),
        .run        (b_run),
        .out_comp   (b_oc),
        .out        (b_out),
        .data_count (b_cnt),
        .err        (b_err)
    );

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // One clock; sample #1 after the edge, score rising DATA, then drive the
    // consumer (out_comp = comp(out) delayed one cycle when following).
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if ((|a_out) && !a_prev) begin
            if (qa.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL a_unexpected_data: got out=%b cnt=%0d, required no DATA", a_out, a_cnt);
            end else begin
                e = qa.pop_front();
                chk("a_data_out", 16'(a_out), 16'(e.o));
                chk("a_data_count", a_cnt, e.c);
            end
        end
        chk("a_onehot", 16'(a_out & (a_out - 4'd1)), 16'd0);
        if (a_follow) a_oc = a_prev;
        a_prev = |a_out;

        if ((|b_out) && !b_prev) begin
            if (qb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL b_unexpected_data: got out=%b cnt=%0d, required no DATA", b_out, b_cnt);
            end else begin
                e = qb.pop_front();
                chk("b_data_out", 16'(b_out), 16'(e.o));
                chk("b_data_count", 16'(b_cnt), e.c);
            end
        end
        chk("b_onehot", 16'(b_out & (b_out - 3'd1)), 16'd0);
        if (b_follow) b_oc = b_prev;
        b_prev = |b_out;
    endtask

    task automatic drain(input bit use_b, input int budget);
        int k = 0;
        while (((use_b ? qb.size() : qa.size()) != 0) && (k < budget)) begin
            tick();
            k++;
        end
        if ((use_b ? qb.size() : qa.size()) != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_timeout: got no DATA within %0d cycles, required next wavefront",
                     use_b ? "b" : "a", budget);
            if (use_b) qb.delete();
            else       qa.delete();
        end
    endtask

    task automatic push_a(input logic [3:0] o, input logic [15:0] c);
        exp_t e;
        e.o = o;
        e.c = c;
        qa.push_back(e);
    endtask

    task automatic reset_a();
        a_init   = 1'b1;
        a_run    = 1'b1;
        a_oc     = 1'b0;
        a_prev   = 1'b0;
        a_follow = 1'b1;
        qa.delete();
        tick();
        chk("a_rst_out", 16'(a_out), 16'd0);
        chk("a_rst_cnt", a_cnt, 16'd0);
        chk("a_rst_err", 16'(a_err), 16'd0);
        a_init = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion by 500us, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        a_init = 1'b1; a_run = 1'b1; a_oc = 1'b0; a_follow = 1'b1; a_prev = 1'b0;
        b_init = 1'b1; b_run = 1'b1; b_oc = 1'b0; b_follow = 1'b1; b_prev = 1'b0;

        for (int i = 0; i < 20; i++) begin
            tab_a[i].freeze  = (i == 10) ? 10 : 0;
            tab_a[i].exp_out = 4'b1000 >> (i % 4);
            tab_a[i].exp_cnt = 16'(i + 1);
        end
        for (int i = 0; i < 5; i++) begin
            tab_b[i].freeze  = 0;
            tab_b[i].exp_out = 4'(3'b100 >> (i % 3));
            tab_b[i].exp_cnt = 16'((i + 1) % 4);
        end

        tick();
        chk("b_rst_out", 16'(b_out), 16'd0);
        chk("b_rst_cnt", 16'(b_cnt), 16'd0);
        chk("b_rst_err", 16'(b_err), 16'd0);

        // Free-running stream with a mid-stream freeze.
        reset_a();
        for (int i = 0; i < 20; i++) begin
            if (tab_a[i].freeze > 0) begin
                a_run = 1'b0;
                for (int t = 0; t < tab_a[i].freeze; t++) begin
                    tick();
                    chk("a_freeze_out", 16'(a_out), 16'(tab_a[i-1].exp_out));
                    chk("a_freeze_cnt", a_cnt, tab_a[i-1].exp_cnt);
                end
                a_run = 1'b1;
            end
            push_a(tab_a[i].exp_out, tab_a[i].exp_cnt);
            drain(1'b0, 40);
        end
        chk("a_stream_cnt", a_cnt, 16'd20);
        chk("a_stream_err", 16'(a_err), 16'd0);

        // Consumer stuck at "DATA accepted": one DATA, one NULL, then silence.
        reset_a();
        push_a(4'b1000, 16'd1);
        drain(1'b0, 40);
        a_follow = 1'b0;
        a_oc     = 1'b1;
        repeat (40) tick();
        chk("a_hold1_out", 16'(a_out), 16'd0);
        chk("a_hold1_cnt", a_cnt, 16'd1);

        // Consumer stuck at "NULL accepted": DATA stays on out.
        reset_a();
        a_follow = 1'b0;
        a_oc     = 1'b0;
        push_a(4'b1000, 16'd1);
        drain(1'b0, 40);
        repeat (30) tick();
        chk("a_hold0_out", 16'(a_out), 16'b1000);
        chk("a_hold0_cnt", a_cnt, 16'd1);

        // Asynchronous init pulse between edges while DATA is on out.
        reset_a();
        push_a(4'b1000, 16'd1);
        push_a(4'b0100, 16'd2);
        push_a(4'b0010, 16'd3);
        drain(1'b0, 120);
        #2;
        a_init = 1'b1;
        a_oc   = 1'b0;
        a_prev = 1'b0;
        #1;
        chk("a_async_out", 16'(a_out), 16'd0);
        chk("a_async_cnt", a_cnt, 16'd0);
        #2;
        a_init = 1'b0;
        push_a(4'b1000, 16'd1);
        drain(1'b0, 40);

        // Illegal multi-hot code in a stage; ring frozen, error still tracked.
        a_run = 1'b0;
        force dut_a.g_stage[1].r_z = 4'b0011;
        tick();
        chk("a_err_set", 16'(a_err), 16'd1);
        release dut_a.g_stage[1].r_z;
        repeat (3) tick();
        chk("a_err_sticky", 16'(a_err), 16'd1);
        a_init = 1'b1;
        a_oc   = 1'b0;
        a_prev = 1'b0;
        tick();
        chk("a_err_clear", 16'(a_err), 16'd0);
        chk("a_err_clear_out", 16'(a_out), 16'd0);

        // Second geometry: three rails, six stages, 2-bit wrapping count.
        b_init = 1'b0;
        for (int i = 0; i < 5; i++) begin
            e_tmp.o = tab_b[i].exp_out;
            e_tmp.c = tab_b[i].exp_cnt;
            qb.push_back(e_tmp);
            drain(1'b1, 60);
        end
        chk("b_final_cnt", 16'(b_cnt), 16'd1);
        chk("b_final_err", 16'(b_err), 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
